// File: rtl/cus43_tilegen.sv
// Two-layer tile pixel serialiser with fine scroll and priority mix
// against an upstream pixel; all outputs registered on CLK_6M.
module cus43_tilegen (
    input  logic        CLK_6M,
    input  logic        RST,
    input  logic        CLK_2H,
    input  logic [2:0]  PRI,
    input  logic [7:0]  CLI,
    input  logic [2:0]  DTI,
    input  logic [11:0] GDI,
    input  logic [7:0]  MDI,
    input  logic [2:0]  CA,
    input  logic        WE,
    input  logic        LATCH,
    input  logic        FLIP,
    input  logic        HA2,
    input  logic        HB2,
    output logic [2:0]  PRO,
    output logic [7:0]  CLO,
    output logic [2:0]  DTO
);

    localparam logic [2:0]  DOT_CLR = 3'b111;
    localparam logic [10:0] PIX_CLR = {DOT_CLR, 8'h00};

    // Index 0 is layer A, index 1 is layer B throughout.
    logic [1:0][1:0]        fx_stg_q, fx_stg_d;
    logic [1:0][1:0]        fx_act_q, fx_act_d;
    logic [1:0][2:0]        pr_stg_q, pr_stg_d;
    logic [1:0][2:0]        pr_act_q, pr_act_d;

    logic [1:0]             load;
    logic [1:0][3:0][2:0]   shf_q, shf_d;
    logic [1:0][7:0]        col_q, col_d;
    logic [1:0][2:0][10:0]  dly_q, dly_d;
    logic [1:0][10:0]       pix_now;
    logic [1:0][10:0]       pix_tap;

    logic [2:0]             pro_q, pro_d;
    logic [7:0]             clo_q, clo_d;
    logic [2:0]             dto_q, dto_d;

    function automatic logic [2:0] px(input logic [11:0] g,
                                      input logic [1:0]  b);
        return {g[{2'b10, b}], g[{2'b01, b}], g[{2'b00, b}]};
    endfunction

    assign load[0] = HA2 & ~CLK_2H;
    assign load[1] = HB2 & CLK_2H;

    // Staged/active register file; LATCH sees the pre-write staged value.
    always_comb begin
        fx_stg_d = fx_stg_q;
        pr_stg_d = pr_stg_q;
        fx_act_d = fx_act_q;
        pr_act_d = pr_act_q;
        if (LATCH) begin
            fx_act_d = fx_stg_q;
            pr_act_d = pr_stg_q;
        end
        if (WE) begin
            case (CA[1:0])
                2'd0:    fx_stg_d[CA[2]] = MDI[1:0];
                2'd1:    pr_stg_d[CA[2]] = MDI[2:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        shf_d = shf_q;
        col_d = col_q;
        for (int l = 0; l < 2; l++) begin
            if (load[l]) begin
                for (int n = 0; n < 4; n++) begin
                    shf_d[l][n] = px(GDI, FLIP ? 2'(n) : ~2'(n));
                end
                col_d[l] = MDI;
            end else begin
                shf_d[l][0] = shf_q[l][1];
                shf_d[l][1] = shf_q[l][2];
                shf_d[l][2] = shf_q[l][3];
                shf_d[l][3] = DOT_CLR;
            end
        end
    end

    always_comb begin
        pix_now = '0;
        pix_tap = '0;
        dly_d   = dly_q;
        for (int l = 0; l < 2; l++) begin
            pix_now[l]  = {shf_q[l][0], col_q[l]};
            dly_d[l][0] = pix_now[l];
            dly_d[l][1] = dly_q[l][0];
            dly_d[l][2] = dly_q[l][1];
            case (fx_act_q[l])
                2'd0:    pix_tap[l] = pix_now[l];
                2'd1:    pix_tap[l] = dly_q[l][0];
                2'd2:    pix_tap[l] = dly_q[l][1];
                default: pix_tap[l] = dly_q[l][2];
            endcase
        end
    end

    // B is tried first so A wins ties with B; >= lets layers win ties
    // with whatever they are compared against.
    always_comb begin
        pro_d = PRI;
        clo_d = CLI;
        dto_d = DTI;
        for (int l = 1; l >= 0; l--) begin
            if (pix_tap[l][10:8] != DOT_CLR && pr_act_q[l] >= pro_d) begin
                pro_d = pr_act_q[l];
                clo_d = pix_tap[l][7:0];
                dto_d = pix_tap[l][10:8];
            end
        end
    end

    always_ff @(posedge CLK_6M) begin
        if (RST) begin
            fx_stg_q <= '0;
            fx_act_q <= '0;
            pr_stg_q <= '0;
            pr_act_q <= '0;
            shf_q    <= {8{DOT_CLR}};
            col_q    <= '0;
            dly_q    <= {6{PIX_CLR}};
            pro_q    <= '0;
            clo_q    <= '0;
            dto_q    <= '0;
        end else begin
            fx_stg_q <= fx_stg_d;
            fx_act_q <= fx_act_d;
            pr_stg_q <= pr_stg_d;
            pr_act_q <= pr_act_d;
            shf_q    <= shf_d;
            col_q    <= col_d;
            dly_q    <= dly_d;
            pro_q    <= pro_d;
            clo_q    <= clo_d;
            dto_q    <= dto_d;
        end
    end

    assign PRO = pro_q;
    assign CLO = clo_q;
    assign DTO = dto_q;

endmodule

// File: tb/tb_cus43_tilegen.sv
// Scoreboard bench for cus43_tilegen: expected pixels queued with the
// cycle they are due, compared on the falling edge.
module tb_cus43_tilegen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_2h = 1'b0;
    logic [2:0]  pri = '0;
    logic [7:0]  cli = '0;
    logic [2:0]  dti = '0;
    logic [11:0] gdi = '0;
    logic [7:0]  mdi = '0;
    logic [2:0]  ca = '0;
    logic        we = 1'b0;
    logic        latch = 1'b0;
    logic        flip = 1'b0;
    logic        ha2 = 1'b0;
    logic        hb2 = 1'b0;
    logic [2:0]  pro;
    logic [7:0]  clo;
    logic [2:0]  dto;

    cus43_tilegen dut (
        .CLK_6M(clk), .RST(rst), .CLK_2H(clk_2h),
        .PRI(pri), .CLI(cli), .DTI(dti),
        .GDI(gdi), .MDI(mdi), .CA(ca), .WE(we),
        .LATCH(latch), .FLIP(flip), .HA2(ha2), .HB2(hb2),
        .PRO(pro), .CLO(clo), .DTO(dto)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [2:0] pro;
        logic [7:0] clo;
        logic [2:0] dto;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cyc_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   c;

    always @(posedge clk) cyc_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc_cnt) begin
            e = sb.pop_front();
            chk({e.tag, ".pro"}, 32'(pro), 32'(e.pro));
            chk({e.tag, ".clo"}, 32'(clo), 32'(e.clo));
            chk({e.tag, ".dto"}, 32'(dto), 32'(e.dto));
        end
    end

    task automatic push(input int due, input logic [2:0] p,
                        input logic [7:0] cl, input logic [2:0] d,
                        input string tag);
        exp_t e;
        e.due = due;
        e.pro = p;
        e.clo = cl;
        e.dto = d;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic push_run(input int due, input int n, input logic [2:0] p,
                            input logic [7:0] cl, input logic [2:0] d,
                            input string tag);
        for (int i = 0; i < n; i++) push(due + i, p, cl, d, tag);
    endtask

    // Every driving step starts at a falling edge with strobes cleared.
    task automatic step();
        @(negedge clk);
        we = 1'b0;
        latch = 1'b0;
        ha2 = 1'b0;
        hb2 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        step();
        ca = a;
        mdi = d;
        we = 1'b1;
    endtask

    task automatic do_latch();
        step();
        latch = 1'b1;
    endtask

    task automatic ld(input logic lyr, input logic [11:0] g,
                      input logic [7:0] m, output int cc);
        step();
        clk_2h = lyr;
        ha2 = ~lyr;
        hb2 = lyr;
        gdi = g;
        mdi = m;
        cc = cyc_cnt;
    endtask

    initial begin
        // Reset held for three clocks
        for (int i = 0; i < 3; i++) begin
            step();
            push(cyc_cnt + 1, 3'd0, 8'h00, 3'd0, "reset");
        end
        step();
        rst = 1'b0;
        push(cyc_cnt + 1, 3'd0, 8'h00, 3'd0, "post_reset");
        idle(2);

        // Basic load on layer A
        wr(3'd1, 8'd2);
        do_latch();
        step();
        pri = 3'd1;
        cli = 8'h11;
        dti = 3'd0;
        idle(2);
        ld(1'b0, 12'hF0A, 8'h5C, c);
        push(c + 1, 3'd1, 8'h11, 3'd0, "a_pre");
        push(c + 2, 3'd2, 8'h5C, 3'd5, "a_px0");
        push(c + 3, 3'd2, 8'h5C, 3'd4, "a_px1");
        push(c + 4, 3'd2, 8'h5C, 3'd5, "a_px2");
        push(c + 5, 3'd2, 8'h5C, 3'd4, "a_px3");
        push(c + 6, 3'd1, 8'h11, 3'd0, "a_post");
        idle(8);

        // Fully transparent group
        ld(1'b0, 12'hFFF, 8'h5C, c);
        push_run(c + 1, 6, 3'd1, 8'h11, 3'd0, "transp");
        idle(8);

        // Priority: tie between layers, then B higher, then upstream
        wr(3'd1, 8'd3);
        wr(3'd5, 8'd3);
        do_latch();
        idle(2);
        ld(1'b1, 12'h000, 8'hBB, c);
        push(c + 2, 3'd3, 8'hBB, 3'd0, "tie_b");
        push_run(c + 3, 4, 3'd3, 8'hAA, 3'd2, "tie_a");
        push(c + 7, 3'd1, 8'h11, 3'd0, "tie_post");
        ld(1'b0, 12'h0F0, 8'hAA, c);
        idle(8);

        wr(3'd5, 8'd4);
        do_latch();
        idle(2);
        ld(1'b1, 12'h000, 8'hBB, c);
        push_run(c + 2, 4, 3'd4, 8'hBB, 3'd0, "bhi_b");
        push(c + 6, 3'd3, 8'hAA, 3'd2, "bhi_a");
        push(c + 7, 3'd1, 8'h11, 3'd0, "bhi_post");
        ld(1'b0, 12'h0F0, 8'hAA, c);
        idle(8);

        step();
        pri = 3'd5;
        idle(1);
        ld(1'b1, 12'h000, 8'hBB, c);
        push_run(c + 1, 7, 3'd5, 8'h11, 3'd0, "up_wins");
        ld(1'b0, 12'h0F0, 8'hAA, c);
        idle(8);

        // Fine scroll of two clocks on layer A
        step();
        pri = 3'd1;
        wr(3'd0, 8'd2);
        do_latch();
        idle(4);
        ld(1'b0, 12'hF0A, 8'h5C, c);
        push_run(c + 1, 3, 3'd1, 8'h11, 3'd0, "fx_pre");
        push(c + 4, 3'd3, 8'h5C, 3'd5, "fx_px0");
        push(c + 5, 3'd3, 8'h5C, 3'd4, "fx_px1");
        push(c + 6, 3'd3, 8'h5C, 3'd5, "fx_px2");
        push(c + 7, 3'd3, 8'h5C, 3'd4, "fx_px3");
        push(c + 8, 3'd1, 8'h11, 3'd0, "fx_post");
        idle(10);

        // Staged priority has no effect until LATCH
        wr(3'd0, 8'd0);
        do_latch();
        wr(3'd1, 8'd6);
        step();
        pri = 3'd5;
        idle(6);
        ld(1'b0, 12'h0F0, 8'hAA, c);
        push_run(c + 1, 6, 3'd5, 8'h11, 3'd0, "staged");
        idle(8);
        do_latch();
        idle(2);
        ld(1'b0, 12'h0F0, 8'hAA, c);
        push_run(c + 2, 4, 3'd6, 8'hAA, 3'd2, "latched");
        push(c + 6, 3'd5, 8'h11, 3'd0, "latched_post");
        idle(8);

        // Flipped pixel order
        step();
        flip = 1'b1;
        ld(1'b0, 12'h001, 8'h3C, c);
        push(c + 2, 3'd6, 8'h3C, 3'd1, "flip0");
        push_run(c + 3, 3, 3'd6, 8'h3C, 3'd0, "flip123");
        push(c + 6, 3'd5, 8'h11, 3'd0, "flip_post");
        idle(8);
        step();
        flip = 1'b0;

        // Layer beats upstream on an equal priority
        step();
        pri = 3'd6;
        idle(2);
        ld(1'b0, 12'h000, 8'h77, c);
        push_run(c + 2, 4, 3'd6, 8'h77, 3'd0, "up_tie");
        idle(8);

        // Reset in the middle of a group discards it
        step();
        pri = 3'd0;
        idle(2);
        ld(1'b0, 12'h000, 8'h77, c);
        step();
        rst = 1'b1;
        push(c + 2, 3'd0, 8'h00, 3'd0, "mid_rst");
        push_run(c + 3, 4, 3'd0, 8'h11, 3'd0, "rst_disc");
        step();
        rst = 1'b0;
        idle(8);

        for (int i = 0; i < 30 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) chk("drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
